// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, write-back selects and state encoding
package wb_pkg;

  localparam int W = 16;
  localparam int N = 3;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PORT = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_MEM = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_mux.sv
// rtl/wb_mux.sv - 4:1 write-back value selector indexed by WBsel
module wb_mux
  import wb_pkg::*;
#(
  parameter int W = wb_pkg::W
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] alu,
  input  logic [W-1:0] mem,
  input  logic [W-1:0] port,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y
);

  always_comb begin
    case (sel)
      WB_ALU:  y = alu;
      WB_MEM:  y = mem;
      WB_PORT: y = port;
      default: y = imm;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - MEM/WB register, late-load wait FSM, register-file write port
module writeback
  import wb_pkg::*;
#(
  parameter int W = wb_pkg::W,
  parameter int N = wb_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [2:0]   WB_signals_in,
  input  logic [N-1:0] dst_in,
  input  logic [W-1:0] alu_res,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] in_port,
  input  logic [W-1:0] mem_data,
  input  logic         mem_valid,
  input  logic         flush,
  output logic         wb_stall,
  output logic         regWrite,
  output logic [N-1:0] WA,
  output logic [W-1:0] WD,
  output logic [15:0]  retired
);

  wb_state_t state, state_nxt;

  logic         l_we;
  logic [1:0]   l_sel;
  logic [N-1:0] l_dst;
  logic [W-1:0] l_alu, l_imm, l_port, l_mem;
  logic [N-1:0] wa_hold;
  logic [W-1:0] wd_hold;
  logic [W-1:0] wd_mux;

  logic       capture;
  logic       cap_we;
  logic [1:0] cap_sel;

  assign capture = in_valid && !flush && (state != WAIT_MEM);
  assign cap_we  = WB_signals_in[2];
  assign cap_sel = WB_signals_in[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE: begin
        if (!capture)
          state_nxt = IDLE;
        else if (cap_we && cap_sel == WB_MEM && !mem_valid)
          state_nxt = WAIT_MEM;
        else
          state_nxt = WRITE;
      end
      WAIT_MEM: begin
        // A flush kills the waiting load even if its data shows up this cycle
        if (flush)          state_nxt = IDLE;
        else if (mem_valid) state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_we   <= 1'b0;
      l_sel  <= WB_ALU;
      l_dst  <= '0;
      l_alu  <= '0;
      l_imm  <= '0;
      l_port <= '0;
      l_mem  <= '0;
    end else if (capture) begin
      l_we   <= cap_we;
      l_sel  <= cap_sel;
      l_dst  <= dst_in;
      l_alu  <= alu_res;
      l_imm  <= imm;
      l_port <= in_port;
      if (mem_valid) l_mem <= mem_data;
    end else if (state == WAIT_MEM && !flush && mem_valid) begin
      l_mem <= mem_data;
    end
  end

  wb_mux #(.W(W)) u_mux (
    .sel  (l_sel),
    .alu  (l_alu),
    .mem  (l_mem),
    .port (l_port),
    .imm  (l_imm),
    .y    (wd_mux)
  );

  // WA/WD show the live write while committing and the last write otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wa_hold <= '0;
      wd_hold <= '0;
      retired <= 16'd0;
    end else begin
      if (regWrite) begin
        wa_hold <= l_dst;
        wd_hold <= wd_mux;
      end
      if (state == WRITE) retired <= retired + 16'd1;
    end
  end

  always_comb begin
    wb_stall = (state == WAIT_MEM);
    regWrite = (state == WRITE) && l_we;
    WA       = regWrite ? l_dst  : wa_hold;
    WD       = regWrite ? wd_mux : wd_hold;
  end

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed vector table plus multi-cycle corner sequences for writeback
module tb_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  WB_signals_in;
  logic [2:0]  dst_in;
  logic [15:0] alu_res, imm, in_port, mem_data;
  logic        mem_valid, flush;
  logic        wb_stall, regWrite;
  logic [2:0]  WA;
  logic [15:0] WD;
  logic [15:0] retired;

  int n_vec;
  int n_fail;
  int exp_ret;

  typedef struct {
    logic        v;
    logic [2:0]  sig;
    logic [2:0]  dst;
    logic [15:0] alu;
    logic [15:0] im;
    logic [15:0] port;
    logic [15:0] mem;
    logic        mv;
    logic        fl;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_st;
    logic [15:0] e_ret;
  } vec_t;

  vec_t tbl [20];

  writeback dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .WB_signals_in (WB_signals_in),
    .dst_in        (dst_in),
    .alu_res       (alu_res),
    .imm           (imm),
    .in_port       (in_port),
    .mem_data      (mem_data),
    .mem_valid     (mem_valid),
    .flush         (flush),
    .wb_stall      (wb_stall),
    .regWrite      (regWrite),
    .WA            (WA),
    .WD            (WD),
    .retired       (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic we, input logic [2:0] wa,
                           input logic [15:0] wd, input logic st, input logic [15:0] ret);
    check({tag, " regWrite"}, {31'd0, regWrite}, {31'd0, we});
    check({tag, " WA"},       {29'd0, WA},       {29'd0, wa});
    check({tag, " WD"},       {16'd0, WD},       {16'd0, wd});
    check({tag, " wb_stall"}, {31'd0, wb_stall}, {31'd0, st});
    check({tag, " retired"},  {16'd0, retired},  {16'd0, ret});
  endtask

  task automatic drive(input logic v, input logic [2:0] sig, input logic [2:0] dst,
                       input logic [15:0] alu, input logic [15:0] im, input logic [15:0] port,
                       input logic [15:0] mem, input logic mv, input logic fl);
    in_valid      = v;
    WB_signals_in = sig;
    dst_in        = dst;
    alu_res       = alu;
    imm           = im;
    in_port       = port;
    mem_data      = mem;
    mem_valid     = mv;
    flush         = fl;
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] sig, input logic [2:0] dst,
                              input logic [15:0] alu, input logic [15:0] im, input logic [15:0] port,
                              input logic [15:0] mem, input logic mv, input logic fl,
                              input logic ew, input logic [2:0] ewa, input logic [15:0] ewd,
                              input logic es, input logic [15:0] er);
    vec_t r;
    r.v = v; r.sig = sig; r.dst = dst; r.alu = alu; r.im = im; r.port = port;
    r.mem = mem; r.mv = mv; r.fl = fl;
    r.e_we = ew; r.e_wa = ewa; r.e_wd = ewd; r.e_st = es; r.e_ret = er;
    return r;
  endfunction

  initial begin
    n_vec  = 0;
    n_fail = 0;

    //            v     sig     dst   alu       imm       port      mem       mv    fl      we    wa    wd        st    ret
    tbl[0]  = mk(1'b1, 3'b100, 3'd5, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b1, 3'd5, 16'h1234, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd5, 16'h1234, 1'b0, 16'd1);
    tbl[2]  = mk(1'b1, 3'b101, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b1, 1'b0,  1'b1, 3'd2, 16'hBEEF, 1'b0, 16'd1);
    tbl[3]  = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd2, 16'hBEEF, 1'b0, 16'd2);
    tbl[4]  = mk(1'b1, 3'b101, 3'd4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd2, 16'hBEEF, 1'b1, 16'd2);
    tbl[5]  = mk(1'b1, 3'b100, 3'd7, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd2, 16'hBEEF, 1'b1, 16'd2);
    tbl[6]  = mk(1'b1, 3'b100, 3'd7, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd2, 16'hBEEF, 1'b1, 16'd2);
    tbl[7]  = mk(1'b1, 3'b100, 3'd7, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd2, 16'hBEEF, 1'b1, 16'd2);
    tbl[8]  = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 1'b1, 1'b0,  1'b1, 3'd4, 16'hCAFE, 1'b0, 16'd2);
    tbl[9]  = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd4, 16'hCAFE, 1'b0, 16'd3);
    tbl[10] = mk(1'b1, 3'b101, 3'd6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd4, 16'hCAFE, 1'b1, 16'd3);
    tbl[11] = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd4, 16'hCAFE, 1'b1, 16'd3);
    tbl[12] = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 1'b1, 1'b1,  1'b0, 3'd4, 16'hCAFE, 1'b0, 16'd3);
    tbl[13] = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd4, 16'hCAFE, 1'b0, 16'd3);
    tbl[14] = mk(1'b1, 3'b111, 3'd1, 16'h0000, 16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b1, 3'd1, 16'h0007, 1'b0, 16'd3);
    tbl[15] = mk(1'b1, 3'b110, 3'd3, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 1'b0, 1'b0,  1'b1, 3'd3, 16'h00FF, 1'b0, 16'd4);
    tbl[16] = mk(1'b1, 3'b000, 3'd5, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd3, 16'h00FF, 1'b0, 16'd5);
    tbl[17] = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd3, 16'h00FF, 1'b0, 16'd6);
    tbl[18] = mk(1'b1, 3'b001, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd3, 16'h00FF, 1'b0, 16'd6);
    tbl[19] = mk(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,  1'b0, 3'd3, 16'h00FF, 1'b0, 16'd7);

    rst = 1'b0;
    drive(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].sig, tbl[i].dst, tbl[i].alu, tbl[i].im, tbl[i].port,
            tbl[i].mem, tbl[i].mv, tbl[i].fl);
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_st, tbl[i].e_ret);
    end
    exp_ret = 7;

    // A flush arriving while an older write is committing leaves that write intact
    drive(1'b1, 3'b100, 3'd6, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 3'b100, 3'd7, 16'h7777, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    #1;
    check_all("flush_in_write", 1'b1, 3'd6, 16'h0A0A, 1'b0, 16'd7);
    @(posedge clk);
    #1;
    exp_ret = 8;
    check_all("after_flush_in_write", 1'b0, 3'd6, 16'h0A0A, 1'b0, exp_ret[15:0]);

    // Stream no-write instructions back to back until the counter wraps
    drive(1'b1, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    repeat (65535 - exp_ret) @(posedge clk);
    #1;
    check("retired_max", {16'd0, retired}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("retired_wrap", {16'd0, retired}, 32'h00000000);
    drive(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("retired_after_wrap", {16'd0, retired}, 32'h00000001);

    // Asynchronous reset in the middle of a memory wait
    drive(1'b1, 3'b101, 3'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_stall", {31'd0, wb_stall}, 32'd1);
    drive(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0);
    #3;
    rst = 1'b1;
    drive(1'b0, 3'b000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_all("dropped_pending", 1'b0, 3'd0, 16'h0000, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
